// File: rtl/dtot_counter.sv
// dtot_counter: modulus up/down counter built from per-bit T toggles on D registers
module dtot_counter #(
  parameter int WIDTH = 4,
  parameter int MOD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t,
  input  logic             edge_mode,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] q_max = WIDTH'(MOD - 1);
  typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;
  state_t state;
  logic t_prev, cnt_en;
  logic [WIDTH-1:0] tv, q_nxt, d_red;
  assign qb = ~q;
  assign tc = up ? (q == q_max) : (q == '0);
  assign d_red = WIDTH'(32'(d) % MOD);
  assign cnt_en = (state == RUN && !edge_mode) ? t :
                  (state == ARMED && edge_mode) ? (t & ~t_prev) : 1'b0;
  assign tv[0] = cnt_en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_t
    assign tv[i] = tv[i-1] & (up ? q[i-1] : ~q[i-1]);
  end
  assign q_nxt = (cnt_en && tc) ? (up ? '0 : q_max) : (q ^ tv);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q      <= '0;
      wrap   <= 1'b0;
      t_prev <= 1'b0;
      state  <= IDLE;
    end else begin
      q      <= load ? d_red : q_nxt;
      wrap   <= !load && cnt_en && tc;
      t_prev <= t;
      state  <= edge_mode ? ARMED : RUN;
    end
endmodule

// File: tb/tb_dtot_counter.sv
// tb_dtot_counter: vector table, corner sequences and random model check of dtot_counter
module tb_dtot_counter;
  logic clk = 1'b0, rst_n = 1'b0, t = 1'b0, edge_mode = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q16, qb16, q10, qb10;
  logic tc16, tc10, wrap16, wrap10;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dtot_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .t(t), .edge_mode(edge_mode), .up(up), .load(load),
    .d(d), .q(q16), .qb(qb16), .tc(tc16), .wrap(wrap16)
  );
  dtot_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .t(t), .edge_mode(edge_mode), .up(up), .load(load),
    .d(d), .q(q10), .qb(qb10), .tc(tc10), .wrap(wrap10)
  );
  typedef struct {
    bit t, em, up, ld;
    logic [3:0] d;
    int q16, q10;
    bit w16, w10;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int e16, input bit w16, input int e10, input bit w10);
    logic [3:0] a16, a10, b16, b10;
    bit t16, t10;
    a16 = 4'(e16);
    a10 = 4'(e10);
    b16 = ~a16;
    b10 = ~a10;
    t16 = up ? (e16 == 15) : (e16 == 0);
    t10 = up ? (e10 == 9) : (e10 == 0);
    chk({tag, " q16"}, 32'(q16), 32'(a16));
    chk({tag, " qb16"}, 32'(qb16), 32'(b16));
    chk({tag, " tc16"}, 32'(tc16), 32'(t16));
    chk({tag, " wrap16"}, 32'(wrap16), 32'(w16));
    chk({tag, " q10"}, 32'(q10), 32'(a10));
    chk({tag, " qb10"}, 32'(qb10), 32'(b10));
    chk({tag, " tc10"}, 32'(tc10), 32'(t10));
    chk({tag, " wrap10"}, 32'(wrap10), 32'(w10));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    t = 1'b0;
    edge_mode = 1'b0;
    up = 1'b0;
    load = 1'b0;
    d = 4'd0;
    @(posedge clk);
    #1;
    chk_all("reset", 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic add(input bit vt, input bit vem, input bit vup, input bit vld, input logic [3:0] vd,
                     input int e16, input int e10, input bit w16, input bit w10);
    vec_t v;
    v.t = vt; v.em = vem; v.up = vup; v.ld = vld; v.d = vd;
    v.q16 = e16; v.q10 = e10; v.w16 = w16; v.w10 = w10;
    tbl.push_back(v);
  endtask
  function automatic int nxt(int q, int m, bit en, bit u, bit ld, int dv);
    if (ld) return dv % m;
    if (!en) return q;
    return u ? (q + 1) % m : (q + m - 1) % m;
  endfunction
  function automatic bit wr(int q, int m, bit en, bit u, bit ld);
    return !ld && en && (u ? q == m - 1 : q == 0);
  endfunction
  initial begin
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,   0, 0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,   1, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 12, 2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  11, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  10, 0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,   9, 9, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,   8, 8, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 4'd7,   7, 7, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 4'd3,   3, 3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,   3, 3, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,   4, 4, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,   4, 4, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,   4, 4, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,   4, 4, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,   5, 5, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'd9,   9, 9, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 4'd5,   5, 5, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,   6, 6, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i].t;
      edge_mode = tbl[i].em;
      up = tbl[i].up;
      load = tbl[i].ld;
      d = tbl[i].d;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].q16, tbl[i].w16, tbl[i].q10, tbl[i].w10);
    end
    do_reset();
    t = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("level%0d", k), (k - 1) % 16, k == 17, (k - 1) % 10, k == 11);
    end
    do_reset();
    t = 1'b1;
    up = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk_all("flip_pre", 15, 1'b0, 5, 1'b0);
    up = 1'b0;
    @(posedge clk);
    #1;
    chk_all("flip", 14, 1'b0, 4, 1'b0);
    do_reset();
    t = 1'b1;
    up = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_all("arst_pre", 5, 1'b0, 5, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_all("arst_now", 0, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("arst_idle", 0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("arst_resume", 1, 1'b0, 1, 1'b0);
    do_reset();
    begin
      int ms, m16, m10, want;
      bit mtp, en, w16, w10;
      ms = 0;
      mtp = 1'b0;
      m16 = 0;
      m10 = 0;
      for (int n = 0; n < 400; n++) begin
        t = 1'($urandom_range(0, 1));
        up = 1'($urandom_range(0, 1));
        load = ($urandom_range(0, 7) == 0);
        d = 4'($urandom);
        if ($urandom_range(0, 15) == 0) edge_mode = ~edge_mode;
        want = edge_mode ? 2 : 1;
        en = (ms == want) && t && (want == 1 || !mtp);
        w16 = wr(m16, 16, en, up, load);
        w10 = wr(m10, 10, en, up, load);
        m16 = nxt(m16, 16, en, up, load, int'(d));
        m10 = nxt(m10, 10, en, up, load, int'(d));
        ms = want;
        mtp = t;
        @(posedge clk);
        #1;
        chk_all($sformatf("rand%0d", n), m16, w16, m10, w10);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
